// File: rtl/elevador_motor_ctrl.sv
// 4-floor elevator scan scheduler producing the 2-bit motor-state code
// (00 parado, 01 subindo, 10 descendo, 11 erro) for the 7-segment display encoder.
module elevador_motor_ctrl #(
  parameter int unsigned TRAVEL_CYCLES = 50_000_000,
  parameter int unsigned DOOR_CYCLES   = 100_000_000
) (
  input  logic       CLOCK_50,
  input  logic       KEY,
  input  logic [9:0] SW,
  output logic [1:0] MOTOR,
  output logic [1:0] FLOOR,
  output logic [3:0] LEDR,
  output logic       DOOR
);

  localparam int unsigned TW = (TRAVEL_CYCLES > 2) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int unsigned DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] TLast = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DLast = DW'(DOOR_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StUp, StDown, StDoor, StError} state_e;

  state_e          r_state, w_state_nxt;
  logic [1:0]      r_floor, w_floor_nxt;
  logic [3:0]      r_req, w_req_nxt;
  logic [TW-1:0]   r_tcnt, w_tcnt_nxt;
  logic [DW-1:0]   r_dcnt, w_dcnt_nxt;
  logic            r_last_up, w_last_up_nxt;
  logic [3:0]      w_set;
  logic [1:0]      w_nf;
  logic            w_more;
  logic            w_unused;

  assign w_unused = ^SW[8:4];

  function automatic logic f_any_above(input logic [3:0] req, input logic [1:0] fl);
    logic a;
    a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > int'(fl)) a = a | req[i];
    end
    return a;
  endfunction

  function automatic logic f_any_below(input logic [3:0] req, input logic [1:0] fl);
    logic b;
    b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(fl)) b = b | req[i];
    end
    return b;
  endfunction

  always_comb begin
    w_set         = SW[3:0];
    w_state_nxt   = r_state;
    w_floor_nxt   = r_floor;
    w_tcnt_nxt    = r_tcnt;
    w_dcnt_nxt    = r_dcnt;
    w_last_up_nxt = r_last_up;
    w_nf          = r_floor;
    w_more        = 1'b0;
    // The floor being served ignores its own button while the door is open.
    if (r_state == StDoor) w_set[r_floor] = 1'b0;
    w_req_nxt = r_req | w_set;

    if (r_state == StError) begin
      w_req_nxt = r_req;
    end else if (SW[9]) begin
      // Emergency beats every other transition and freezes floor, travel and requests.
      w_state_nxt = StError;
      w_req_nxt   = r_req;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (r_req[r_floor]) begin
            w_state_nxt        = StDoor;
            w_req_nxt[r_floor] = 1'b0;
          end else if (r_last_up && f_any_above(r_req, r_floor)) begin
            w_state_nxt = StUp;
          end else if (f_any_below(r_req, r_floor)) begin
            w_state_nxt = StDown;
          end else if (f_any_above(r_req, r_floor)) begin
            w_state_nxt = StUp;
          end
        end
        StUp, StDown: begin
          w_nf   = (r_state == StUp) ? r_floor + 2'd1 : r_floor - 2'd1;
          w_more = (r_state == StUp) ? f_any_above(r_req, w_nf) : f_any_below(r_req, w_nf);
          if (r_tcnt == TLast) begin
            w_tcnt_nxt    = '0;
            w_floor_nxt   = w_nf;
            w_last_up_nxt = (r_state == StUp);
            if (r_req[w_nf]) begin
              w_state_nxt     = StDoor;
              w_req_nxt[w_nf] = 1'b0;
            end else if (!w_more) begin
              w_state_nxt = StIdle;
            end
          end else begin
            w_tcnt_nxt = r_tcnt + 1'b1;
          end
        end
        StDoor: begin
          if (r_dcnt == DLast) begin
            w_dcnt_nxt  = '0;
            w_state_nxt = StIdle;
          end else begin
            w_dcnt_nxt = r_dcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!KEY) begin
      r_state   <= StIdle;
      r_floor   <= '0;
      r_req     <= '0;
      r_tcnt    <= '0;
      r_dcnt    <= '0;
      r_last_up <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_floor   <= w_floor_nxt;
      r_req     <= w_req_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_dcnt    <= w_dcnt_nxt;
      r_last_up <= w_last_up_nxt;
    end
  end

  always_comb begin
    MOTOR = 2'b00;
    DOOR  = 1'b0;
    unique case (r_state)
      StUp:    MOTOR = 2'b01;
      StDown:  MOTOR = 2'b10;
      StDoor:  DOOR  = 1'b1;
      StError: MOTOR = 2'b11;
      default: ;
    endcase
  end

  assign FLOOR = r_floor;
  assign LEDR  = r_req;

endmodule

// File: doc/elevador_motor_ctrl.md
Name: elevador_motor_ctrl

Overview:
- Sequential 4-floor elevator controller that produces the 2-bit motor state code consumed by the team's 7-segment motor-state display encoder.
- Code: 00 = parado, 01 = subindo, 10 = descendo, 11 = erro.
- Latches floor requests from switches, models travel time with a counter, runs a direction-preserving scan scheduler and holds the door open at served floors.
- Top-level DE-board block: MOTOR drives the display encoder's 2-bit input.

Parameters:
- TRAVEL_CYCLES, 50_000_000: clock cycles to move one floor; minimum 2.
- DOOR_CYCLES, 100_000_000: clock cycles the door stays open; minimum 1.

Ports:
- CLOCK_50  input  1  system clock; all logic on rising edge.
- KEY  input  1  reset, synchronous, active-low (KEY=0 resets on the next edge).
- SW  input  10  SW[3:0] floor-request buttons, level, one per floor; SW[9] emergency, active-high; SW[8:4] unused.
- MOTOR  output  2  motor state code.
- FLOOR  output  2  current floor, 0..3.
- LEDR  output  4  pending request bits.
- DOOR  output  1  1 while door is open.

Behaviour:
- Reset: on a clock edge with KEY=0, all registers clear.
  - state=IDLE, FLOOR=0, LEDR=0, DOOR=0, MOTOR=00, tcnt=0, dcnt=0, last_dir=UP.
  - Reset overrides everything, including ERROR and mid-travel.
- Request latch: req[i] <= req[i] | SW[i] every cycle.
  - Exception: SW[i] is not latched when i==FLOOR and state==DOOR.
  - req[i] is cleared on the cycle the FSM enters DOOR at floor i; the clear wins over a simultaneous set.
  - LEDR = req.
- FSM decisions use only the registered req, so SW-to-MOTOR latency is 2 cycles.
- States and MOTOR, registered and decoded directly from state:
  - IDLE → 00
  - UP → 01
  - DOWN → 10
  - DOOR → 00, DOOR=1
  - ERROR → 11
- Definitions: above = |req[3:FLOOR+1]; below = |req[FLOOR-1:0]; both are 0 at the floor-3 and floor-0 boundaries respectively.
- IDLE: checks in this order, first match wins.
  - req[FLOOR] → DOOR.
  - last_dir==UP and above → UP.
  - below → DOWN.
  - above → UP.
  - Otherwise stay in IDLE.
- UP / DOWN:
  - tcnt increments each cycle.
  - At tcnt==TRAVEL_CYCLES-1: tcnt<=0, FLOOR<=FLOOR±1, last_dir<=current direction, then evaluate req at the new floor:
    - req set → DOOR.
    - else requests remain further in the same direction → stay.
    - else → IDLE.
  - FLOOR never wraps. Entering UP at floor 3 or DOWN at floor 0 is impossible by construction; the verifier asserts this.
- DOOR:
  - dcnt counts 0..DOOR_CYCLES-1, then dcnt<=0 and go to IDLE.
  - DOOR is high for exactly DOOR_CYCLES cycles.
- ERROR:
  - Entered from any state on the edge after SW[9]=1 (higher priority than any other transition).
  - FLOOR, tcnt and req are frozen; DOOR=0.
  - Sticky: exits only via reset, even if SW[9] returns to 0.
  - Requests are not latched while in ERROR.
- Simultaneous requests above and below while moving: the current direction is served to its end before reversing (scan).

Test Plan (TRAVEL_CYCLES=4, DOOR_CYCLES=3):
- Reset: KEY=0 for 2 cycles, SW=0 → MOTOR=00, FLOOR=0, LEDR=0000, DOOR=0; hold 10 cycles → no change.
- Single trip: 1-cycle pulse on SW[2] at floor 0.
  - LEDR=0100 one edge later; MOTOR=01 the edge after.
  - FLOOR=1 after 4 cycles; FLOOR=2 after 8 cycles.
  - Same edge: DOOR=1, MOTOR=00, LEDR=0000.
  - DOOR high exactly 3 cycles, then IDLE.
- Scan order: at floor 2, last_dir=UP, SW[3] and SW[0] pulsed together.
  - Goes UP to 3, door cycle, then DOWN (MOTOR=10) to 0.
  - FLOOR sequence 2,3,2,1,0; LEDR 1001→0001→0000.
- Current-floor request: idle at floor 1, pulse SW[1] → DOOR=1 two edges later, MOTOR stays 00, FLOOR stays 1.
- Emergency mid-travel: SW[9]=1 while tcnt=2 between floors 0 and 1.
  - Next edge MOTOR=11, FLOOR=0 frozen, LEDR frozen.
  - Clear SW[9] → still 11.
  - KEY=0 → MOTOR=00, FLOOR=0.
- Reset mid-door: KEY=0 during DOOR at floor 2 → next edge DOOR=0, FLOOR=0, LEDR=0000, MOTOR=00.
